// File: rtl/ysyx_24080006_ex_dispatch_pkg.sv
// Shared types for the execute-stage dispatcher.
// FSM encoding and functional-unit indices.
package ysyx_24080006_ex_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } ex_dispatch_fsm_e;

  localparam int FU_LSU = 0;
  localparam int FU_MDU = 1;

endpackage

// File: rtl/ysyx_24080006_ex_dispatch_if.sv
// Request/response bus between the dispatcher
// and its multi-cycle functional units.
interface ysyx_24080006_ex_dispatch_if #(
  parameter int NUM_UNITS = 2,
  parameter int XLEN      = 32
);

  logic [NUM_UNITS-1:0]           fu_req_valid;
  logic [NUM_UNITS-1:0]           fu_req_ready;
  logic [NUM_UNITS-1:0]           fu_resp_valid;
  logic [NUM_UNITS-1:0]           fu_resp_we;
  logic [NUM_UNITS-1:0][XLEN-1:0] fu_resp_data;
  logic [NUM_UNITS-1:0]           fu_resp_ready;

  modport master (
    output fu_req_valid,
    input  fu_req_ready,
    input  fu_resp_valid,
    input  fu_resp_we,
    input  fu_resp_data,
    output fu_resp_ready
  );

  modport slave (
    input  fu_req_valid,
    output fu_req_ready,
    output fu_resp_valid,
    output fu_resp_we,
    output fu_resp_data,
    input  fu_resp_ready
  );

endinterface

// File: rtl/ysyx_24080006_onehot_lsb.sv
// Lowest-set-bit select with binary index encode.
// Extra request bits above the lowest are dropped.
module ysyx_24080006_onehot_lsb #(
  parameter int W  = 2,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req_i,
  output logic [W-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  assign gnt_o = req_i & (~req_i + W'(1));

  // scan high to low so the lowest set bit wins
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/ysyx_24080006_ex_dispatch.sv
// Execute-stage dispatcher: bypass writeback,
// in-order multi-cycle unit ops, watchdog, perf.
module ysyx_24080006_ex_dispatch
  import ysyx_24080006_ex_dispatch_pkg::*;
#(
  parameter int NUM_UNITS = 2,
  parameter int XLEN      = 32,
  parameter int REG_W     = 5,
  parameter int TIMEOUT   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_UNITS-1:0] in_sel,
  input  logic                 in_reg_we,
  input  logic [REG_W-1:0]     in_rd_addr,
  input  logic [XLEN-1:0]      in_data,
  ysyx_24080006_ex_dispatch_if.master fu,
  output logic                 wb_valid,
  output logic                 wb_reg_we,
  output logic [REG_W-1:0]     wb_rd_addr,
  output logic [XLEN-1:0]      wb_data,
  output logic                 fwd_en,
  output logic [XLEN-1:0]      fwd_data,
  output logic                 done,
  output logic                 timeout_err,
  output logic [NUM_UNITS-1:0] perf_issue,
  output logic [NUM_UNITS-1:0] perf_busy
);

  localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  ex_dispatch_fsm_e state_q, state_d;

  logic [NUM_UNITS-1:0] act_q, act_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [REG_W-1:0]     rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 wbv_q, wbv_d;
  logic                 wbwe_q, wbwe_d;
  logic [REG_W-1:0]     wbrd_q, wbrd_d;
  logic [XLEN-1:0]      wbdat_q, wbdat_d;
  logic                 terr_q, terr_d;
  logic [NUM_UNITS-1:0] iss_q, iss_d;
  logic [NUM_UNITS-1:0] busy_q, busy_d;

  logic [NUM_UNITS-1:0] sel_oh;
  logic [IW-1:0]        sel_idx;
  logic                 accept;
  logic                 busy_st;
  logic                 req_rdy;
  logic                 resp_v;
  logic                 resp_we;
  logic [XLEN-1:0]      resp_dat;
  logic                 wd_hit;
  logic                 fin;
  logic                 tmo;

  ysyx_24080006_onehot_lsb #(
    .W  (NUM_UNITS),
    .IW (IW)
  ) u_sel (
    .req_i (in_sel),
    .gnt_o (sel_oh),
    .idx_o (sel_idx)
  );

  assign busy_st  = (state_q != IDLE);
  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;
  assign req_rdy  = fu.fu_req_ready[idx_q];
  assign resp_v   = fu.fu_resp_valid[idx_q];
  assign resp_we  = fu.fu_resp_we[idx_q];
  assign resp_dat = fu.fu_resp_data[idx_q];

  assign wd_hit = (TIMEOUT > 0)
               && (cnt_q == CW'(TIMEOUT - 1));

  assign fin = ((state_q == ISSUE) & req_rdy & resp_v)
             | ((state_q == WAIT) & resp_v);
  assign tmo = busy_st & ~fin & wd_hit;

  assign fu.fu_req_valid  = (state_q == ISSUE) ? act_q : '0;
  assign fu.fu_resp_ready = busy_st ? act_q : '0;

  assign fwd_en   = busy_st ? (resp_v & resp_we)
                            : (wbv_q & wbwe_q);
  assign fwd_data = busy_st ? resp_dat : wbdat_q;

  assign wb_valid    = wbv_q;
  assign done        = wbv_q;
  assign wb_reg_we   = wbwe_q;
  assign wb_rd_addr  = wbrd_q;
  assign wb_data     = wbdat_q;
  assign timeout_err = terr_q;
  assign perf_issue  = iss_q;
  assign perf_busy   = busy_q;

  // next state, unit latch, watchdog and writeback
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    wbv_d   = 1'b0;
    wbwe_d  = wbwe_q;
    wbrd_d  = wbrd_q;
    wbdat_d = wbdat_q;
    terr_d  = 1'b0;
    iss_d   = '0;
    busy_d  = busy_st ? busy_q : '0;
    unique case (state_q)
      IDLE: begin
        if (accept && (|in_sel)) begin
          state_d = ISSUE;
          act_d   = sel_oh;
          idx_d   = sel_idx;
          rd_d    = in_rd_addr;
          cnt_d   = '0;
          iss_d   = sel_oh;
          busy_d  = sel_oh;
        end else if (accept) begin
          wbv_d   = 1'b1;
          wbwe_d  = in_reg_we;
          wbrd_d  = in_rd_addr;
          wbdat_d = in_data;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (req_rdy) state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
    if (fin || tmo) begin
      state_d = IDLE;
      wbv_d   = 1'b1;
      wbwe_d  = fin & resp_we;
      wbrd_d  = rd_q;
      terr_d  = tmo;
      if (fin) wbdat_d = resp_dat;
    end
  end

  // state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      act_q   <= '0;
      idx_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      wbv_q   <= 1'b0;
      wbwe_q  <= 1'b0;
      wbrd_q  <= '0;
      wbdat_q <= '0;
      terr_q  <= 1'b0;
      iss_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      wbv_q   <= wbv_d;
      wbwe_q  <= wbwe_d;
      wbrd_q  <= wbrd_d;
      wbdat_q <= wbdat_d;
      terr_q  <= terr_d;
      iss_q   <= iss_d;
      busy_q  <= busy_d;
    end
  end

endmodule
